// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin front end for a single-port word BRAM.
// Registers the BRAM controls and routes read data / address errors back two cycles after grant.
module bram_port_arbiter #(
    parameter int MAX_WORD = 10000,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_we,
    input  logic [31:0]   r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    output logic          r0_err,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_we,
    input  logic [31:0]   r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          r1_err,
    output logic          bram_en,
    output logic [3:0]    bram_wen,
    output logic [31:0]   bram_addr,
    output logic [DW-1:0] bram_din,
    input  logic [DW-1:0] bram_dout
);

    logic          last_q, last_d;
    logic          gnt0, gnt1, hs, sel, sel_we, addr_ok;
    logic [31:0]   sel_addr;
    logic [DW-1:0] sel_wdata;

    logic          en_q, en_d;
    logic [3:0]    wen_q, wen_d;
    logic [31:0]   addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;

    // Response pipeline: stage 1 is the issue cycle, stage 2 is the data-return cycle.
    logic [2:1] vld_q, id_q, rd_q, err_q;

    always_comb begin
        gnt0      = r0_valid & (~r1_valid | last_q);
        gnt1      = r1_valid & (~r0_valid | ~last_q);
        r0_ready  = gnt0 & rst;
        r1_ready  = gnt1 & rst;
        hs        = r0_ready | r1_ready;
        sel       = r1_ready;
        sel_we    = sel ? r1_we    : r0_we;
        sel_addr  = sel ? r1_addr  : r0_addr;
        sel_wdata = sel ? r1_wdata : r0_wdata;
        addr_ok   = (sel_addr[1:0] == 2'b00) && ({2'b00, sel_addr[31:2]} <= 32'(MAX_WORD));
    end

    always_comb begin
        last_d = last_q;
        en_d   = 1'b0;
        wen_d  = 4'b0000;
        addr_d = addr_q;
        din_d  = din_q;
        if (hs) begin
            last_d = sel;
            if (addr_ok) begin
                en_d   = 1'b1;
                wen_d  = sel_we ? 4'b1111 : 4'b0000;
                addr_d = sel_addr;
                din_d  = sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
            en_q   <= 1'b0;
            wen_q  <= 4'b0000;
            addr_q <= '0;
            din_q  <= '0;
            vld_q  <= '0;
            id_q   <= '0;
            rd_q   <= '0;
            err_q  <= '0;
        end else begin
            last_q   <= last_d;
            en_q     <= en_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            vld_q[1] <= hs;
            id_q[1]  <= sel;
            rd_q[1]  <= ~sel_we;
            err_q[1] <= ~addr_ok;
            vld_q[2] <= vld_q[1];
            id_q[2]  <= id_q[1];
            rd_q[2]  <= rd_q[1];
            err_q[2] <= err_q[1];
        end
    end

    assign bram_en   = en_q;
    assign bram_wen  = wen_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;

    assign r0_rvalid = vld_q[2] & rd_q[2] & ~err_q[2] & ~id_q[2];
    assign r1_rvalid = vld_q[2] & rd_q[2] & ~err_q[2] &  id_q[2];
    assign r0_err    = vld_q[2] & err_q[2] & ~id_q[2];
    assign r1_err    = vld_q[2] & err_q[2] &  id_q[2];
    assign r0_rdata  = r0_rvalid ? bram_dout : '0;
    assign r1_rdata  = r1_rvalid ? bram_dout : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a behavioural BRAM, an arbitration/issue model
// and a response scoreboard checked every cycle.
module tb_bram_port_arbiter;

    localparam int MAXW = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_we, r0_rvalid, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_valid, r1_ready, r1_we, r1_rvalid, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic        bram_en;
    logic [3:0]  bram_wen;
    logic [31:0] bram_addr, bram_din, bram_dout;

    always #5 clk = ~clk;

    bram_port_arbiter #(.MAX_WORD(MAXW), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_dout(bram_dout)
    );

    // Write-first BRAM, one-cycle read latency
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_wen == 4'hF) begin
                mem[bram_addr[7:2]] <= bram_din;
                bram_dout           <= bram_din;
            end else begin
                bram_dout <= mem[bram_addr[7:2]];
            end
        end
    end

    typedef struct {
        int          due;
        logic        id;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sbq[$];
    int          vecs = 0, errs = 0, cyc = 0;
    logic        ref_last;
    logic [31:0] ref_mem [0:63];
    logic        cur_en, nx_en;
    logic [3:0]  cur_wen, nx_wen;
    logic [31:0] cur_addr, nx_addr, cur_din, nx_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        ref_last = 1'b1;
        cur_en   = 1'b0;
        cur_wen  = 4'h0;
        nx_en    = 1'b0;
        nx_wen   = 4'h0;
    endtask

    // Checks everything visible in the current cycle, then advances the model by one handshake.
    task automatic eval();
        logic        g0, g1, sel, we, ok, erv0, erv1, eer0, eer1;
        logic [31:0] a, wd, edata;
        rsp_t        r;
        g0 = 1'b0; g1 = 1'b0;
        if (r0_valid && r1_valid) begin
            g0 = ref_last;
            g1 = ~ref_last;
        end else begin
            g0 = r0_valid;
            g1 = r1_valid;
        end
        g0 = g0 & rst;
        g1 = g1 & rst;
        chk("r0_ready", r0_ready, g0);
        chk("r1_ready", r1_ready, g1);

        chk("bram_en", bram_en, cur_en);
        chk("bram_wen", bram_wen, cur_wen);
        if (cur_en) begin
            chk("bram_addr", bram_addr, cur_addr);
            if (cur_wen == 4'hF) chk("bram_din", bram_din, cur_din);
        end

        erv0 = 0; erv1 = 0; eer0 = 0; eer1 = 0; edata = 0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            r = sbq.pop_front();
            if (r.err) begin
                if (r.id) eer1 = 1; else eer0 = 1;
            end else begin
                if (r.id) erv1 = 1; else erv0 = 1;
                edata = r.data;
            end
        end
        chk("r0_rvalid", r0_rvalid, erv0);
        chk("r1_rvalid", r1_rvalid, erv1);
        chk("r0_err", r0_err, eer0);
        chk("r1_err", r1_err, eer1);
        chk("r0_rdata", r0_rdata, erv0 ? edata : 32'h0);
        chk("r1_rdata", r1_rdata, erv1 ? edata : 32'h0);

        nx_en = 1'b0; nx_wen = 4'h0; nx_addr = cur_addr; nx_din = cur_din;
        if (g0 || g1) begin
            sel      = g1;
            ref_last = sel;
            we       = sel ? r1_we    : r0_we;
            a        = sel ? r1_addr  : r0_addr;
            wd       = sel ? r1_wdata : r0_wdata;
            ok       = (a[1:0] == 2'b00) && ((a >> 2) <= 32'(MAXW));
            if (ok) begin
                nx_en   = 1'b1;
                nx_wen  = we ? 4'hF : 4'h0;
                nx_addr = a;
                nx_din  = wd;
                if (we) ref_mem[a[7:2]] = wd;
                else    sbq.push_back('{due: cyc + 2, id: sel, err: 1'b0, data: ref_mem[a[7:2]]});
            end else begin
                sbq.push_back('{due: cyc + 2, id: sel, err: 1'b1, data: 32'h0});
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
        cyc++;
        cur_en = rst ? nx_en  : 1'b0;
        cur_wen = rst ? nx_wen : 4'h0;
        cur_addr = nx_addr;
        cur_din  = nx_din;
    endtask

    task automatic req0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic req1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    task automatic idle(input int n);
        req0(0, 0, 0, 0);
        req1(0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b0;
        req0(0, 0, 0, 0);
        req1(0, 0, 0, 0);
        cur_addr = 0; cur_din = 0; nx_addr = 0; nx_din = 0;
        model_reset();
        #1;
        chk("rst_bram_en", bram_en, 1'b0);
        chk("rst_bram_wen", bram_wen, 4'h0);
        chk("rst_bram_addr", bram_addr, 32'h0);
        chk("rst_bram_din", bram_din, 32'h0);
        chk("rst_r0_rvalid", r0_rvalid, 1'b0);
        chk("rst_r1_err", r1_err, 1'b0);
        step();
        step();
        rst = 1'b1;

        // Write then read back on requester 0
        req0(1, 1, 32'h10, 32'hDEADBEEF);
        step();
        idle(3);
        req0(1, 0, 32'h10, 0);
        step();
        idle(3);

        // Seed more words, including the highest legal word
        req1(1, 1, 32'h14, 32'h12345678); step();
        req1(1, 1, 32'h18, 32'hA5A55A5A); step();
        req1(1, 1, 32'(4 * MAXW), 32'hCAFEF00D); step();
        idle(3);

        // Contention: both hold reads for 6 cycles, grants alternate
        req0(1, 0, 32'h10, 0);
        req1(1, 0, 32'h14, 0);
        for (int i = 0; i < 6; i++) step();
        idle(3);

        // Write then read of the same word in consecutive cycles
        req0(1, 1, 32'h18, 32'h0BADF00D); step();
        req0(1, 0, 32'h18, 0); step();
        idle(3);

        // Misaligned and out-of-range, read and write
        req1(1, 0, 32'h6, 0); step();
        req1(1, 1, 32'(4 * (MAXW + 1)), 32'h1); step();
        idle(3);

        // Only r1 valid: three back-to-back reads
        req1(1, 0, 32'h10, 0); step();
        req1(1, 0, 32'h14, 0); step();
        req1(1, 0, 32'h18, 0); step();
        idle(3);

        // Leave last_grant at 0, then reset during T+1 of an accepted r0 read
        req0(1, 0, 32'h14, 0); step();
        idle(0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_bram_en", bram_en, 1'b0);
        chk("midrst_r0_rvalid", r0_rvalid, 1'b0);
        step();
        step();
        rst = 1'b1;
        req0(1, 0, 32'h10, 0);
        req1(1, 0, 32'h14, 0);
        #1;
        chk("post_rst_r0_first", r0_ready, 1'b1);
        step();
        step();
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Round-robin arbiter that shares the single-port word BRAM interface between two requesters.
  - Requester 0: CNN engine feature/weight fetch.
  - Requester 1: host/DMA loader.
- Converts per-requester valid/ready word requests into registered BRAM controls (en, wen, byte addr, din).
- Returns read data to the owning requester with fixed latency.
- Rejects misaligned and out-of-range addresses.
- Sits between the engine/loader and the BRAM wrapper.

Parameters:
- MAX_WORD, 10000: highest legal word index; a byte address is legal when (addr>>2) <= MAX_WORD.
- DW, 32: data width; fixed at 32 for this BRAM.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- r0_valid  in  1  requester 0 request valid
- r0_ready  out  1  requester 0 request accepted this cycle
- r0_we  in  1  1 = write, 0 = read
- r0_addr  in  32  byte address
- r0_wdata  in  32  write data
- r0_rvalid  out  1  read data valid for requester 0
- r0_rdata  out  32  read data
- r0_err  out  1  request rejected (bad address)
- r1_valid, r1_ready, r1_we, r1_addr, r1_wdata, r1_rvalid, r1_rdata, r1_err: same as r0_*, for requester 1
- bram_en  out  1  BRAM enable
- bram_wen  out  4  BRAM byte write enable; 4'b1111 or 4'b0000 only
- bram_addr  out  32  BRAM byte address
- bram_din  out  32  BRAM write data
- bram_dout  in  32  BRAM read data, valid one cycle after en

Behaviour:
- Reset (rst=0, async):
  - bram_en=0, bram_wen=0, bram_addr=0, bram_din=0.
  - rN_rvalid=0, rN_err=0.
  - Round-robin pointer last_grant=1, so requester 0 wins first.
  - All in-flight pipeline entries cleared; their responses are never delivered.
- Arbitration (combinational, every cycle):
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - rN_ready=1 only for the granted requester, and only when rst=1.
  - Handshake = valid & ready.
  - last_grant updates on handshake only.
- Requesters hold valid/addr/we/wdata stable until ready; the arbiter does not check this.
- Issue stage (registered, edge ending cycle T where handshake occurs):
  - bram_en=1, bram_addr=addr, bram_din=wdata, bram_wen = we ? 4'b1111 : 4'b0000.
  - Visible during T+1.
  - No handshake in T: bram_en=0 and bram_wen=0 in T+1; addr/din hold their last values.
- Address check at handshake:
  - Bad address = addr[1:0]!=0 or (addr>>2)>MAX_WORD.
  - Handshake still completes, but bram_en stays 0 in T+1.
  - rN_err pulses for one cycle in T+2, for reads and writes.
- Response path:
  - Pipeline tracks {valid, id, is_read, err} for 2 stages.
  - Good read issued in T: rN_rvalid=1 for exactly cycle T+2.
  - rN_rdata = bram_dout during the rvalid cycle; 0 otherwise.
  - Writes produce no rvalid.
- Throughput: one request per cycle. Back-to-back reads from alternating requesters return in grant order, one per cycle. No response backpressure; requesters must accept rvalid.
- Simultaneous events: a read and a write to the same word in consecutive cycles are applied in grant order. A read issued the cycle after a write returns the new data (BRAM write-first across cycles).
- Reset asserted mid-operation: outputs drop to reset values immediately; pending rvalid/err are lost.

Test Plan:
- Reset, then r0 writes 0xDEADBEEF to addr 0x10 → cycle T+1: bram_en=1, bram_wen=4'b1111, bram_addr=0x10; no r0_rvalid.
- r0 reads 0x10 after the write → r0_rvalid=1 at T+2 with r0_rdata=0xDEADBEEF; bram_wen=0 during issue.
- r0 and r1 hold valid reads continuously for 6 cycles → grants alternate 0,1,0,1,0,1; each rvalid routed to the correct requester 2 cycles after its grant.
- r1 requests addr 0x6 (misaligned) and addr 4*10001 (out of range) → bram_en stays 0; r1_err pulses at T+2 for each; no r1_rvalid.
- Only r1 valid, 3 back-to-back reads → r1_ready=1 every cycle; 3 consecutive r1_rvalid cycles.
- Drop rst to 0 during cycle T+1 of an accepted read → bram_en=0 and r0_rvalid never asserts; after release, r0 wins first arbitration against r1.
